// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim write-back, line read, one-cycle install.
// Define CACHE_REFILL_PERF_EN to add saturating miss_cnt / wb_cnt performance counters.
module cache_refill_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         miss,
    input  logic                         mem_wb,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [LINE_WORDS-1:0][31:0]  wb_words,
    output logic                         update,
    output logic [LINE_WORDS-1:0][31:0]  words,
    output logic                         stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [LINE_WORDS-1:0][31:0]  mem_wdata,
    input  logic                         mem_ack,
    input  logic [LINE_WORDS-1:0][31:0]  mem_rdata
`ifdef CACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                  miss_cnt,
    output logic [31:0]                  wb_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StWriteback, StFill, StUpdate} state_e;

    state_e                        state_q, state_d;
    logic [ADDR_W-5:0]             line_q;
    logic [ADDR_W-5:0]             wb_line_q;
    logic [LINE_WORDS-1:0][31:0]   wb_data_q;
    logic [LINE_WORDS-1:0][31:0]   buf_q;
    logic                          capture_miss;
    logic                          capture_fill;
    logic                          wb_done;

    // Offset bits within a line are never needed.
    logic unused_offsets;
    assign unused_offsets = ^{addr[3:0], wb_addr[3:0]};

    always_comb begin
        state_d      = state_q;
        capture_miss = 1'b0;
        capture_fill = 1'b0;
        wb_done      = 1'b0;
        update       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    capture_miss = 1'b1;
                    state_d      = mem_wb ? StWriteback : StFill;
                end
            end
            StWriteback: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {wb_line_q, 4'b0000};
                if (mem_ack) begin
                    wb_done = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {line_q, 4'b0000};
                if (mem_ack) begin
                    capture_fill = 1'b1;
                    state_d      = StUpdate;
                end
            end
            StUpdate: begin
                update  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall     = (state_q != StIdle) || miss;
    assign words     = buf_q;
    assign mem_wdata = wb_data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            line_q    <= '0;
            wb_line_q <= '0;
            wb_data_q <= '0;
            buf_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture_miss) begin
                line_q <= addr[ADDR_W-1:4];
                if (mem_wb) begin
                    wb_line_q <= wb_addr[ADDR_W-1:4];
                    wb_data_q <= wb_words;
                end
            end
            if (capture_fill) begin
                buf_q <= mem_rdata;
            end
        end
    end

`ifdef CACHE_REFILL_PERF_EN
    logic [31:0] miss_cnt_q, wb_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (capture_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (wb_done && (wb_cnt_q != 32'hFFFF_FFFF)) begin
                wb_cnt_q <= wb_cnt_q + 32'd1;
            end
        end
    end

    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised bench for cache_refill_ctrl: a request-queue model predicts every output each cycle.
// Directed sequences pin latency, addresses and reset behaviour with literal expectations.
module tb_cache_refill_ctrl;

    logic          CLK;
    logic          RST;
    logic          miss;
    logic          mem_wb;
    logic [31:0]   addr;
    logic [31:0]   wb_addr;
    logic [127:0]  wb_words;
    logic          update;
    logic [127:0]  words;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic          mem_ack;
    logic [127:0]  mem_rdata;
`ifdef CACHE_REFILL_PERF_EN
    logic [31:0]   miss_cnt;
    logic [31:0]   wb_cnt;
`endif

    cache_refill_ctrl #(.ADDR_W(32), .LINE_WORDS(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .miss      (miss),
        .mem_wb    (mem_wb),
        .addr      (addr),
        .wb_addr   (wb_addr),
        .wb_words  (wb_words),
        .update    (update),
        .words     (words),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef CACHE_REFILL_PERF_EN
        ,
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errs   = 0;
    int checks = 0;

    // Model: outstanding memory operations in order, then a pending install.
    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } req_t;

    req_t          mq[$];
    logic          m_upd;
    logic [127:0]  m_buf;
    logic [31:0]   m_miss_cnt;
    logic [31:0]   m_wb_cnt;

    logic          obs_update;
    logic          obs_stall;
    logic          obs_req;
    logic          obs_we;
    logic [31:0]   obs_addr;
    logic [127:0]  obs_wdata;
    logic [127:0]  obs_words;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_upd      = 1'b0;
        m_buf      = '0;
        m_miss_cnt = '0;
        m_wb_cnt   = '0;
    endfunction

    function automatic void model_step();
        req_t r;
        if (m_upd) begin
            m_upd = 1'b0;
        end else if (mq.size() != 0) begin
            if (mem_ack) begin
                r = mq.pop_front();
                if (r.we) begin
                    if (m_wb_cnt != 32'hFFFF_FFFF) m_wb_cnt = m_wb_cnt + 1;
                end else begin
                    m_buf = mem_rdata;
                    m_upd = 1'b1;
                end
            end
        end else if (miss) begin
            if (m_miss_cnt != 32'hFFFF_FFFF) m_miss_cnt = m_miss_cnt + 1;
            if (mem_wb) mq.push_back('{we: 1'b1, addr: wb_addr, data: wb_words});
            mq.push_back('{we: 1'b0, addr: {addr[31:4], 4'b0000}, data: '0});
        end
    endfunction

    task automatic compare();
        logic busy;
        busy = (mq.size() != 0) || m_upd;
        chk("stall", stall, busy || miss);
        chk("mem_req", mem_req, mq.size() != 0);
        chk("mem_we", mem_we, (mq.size() != 0) ? mq[0].we : 1'b0);
        if (mq.size() != 0) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].data);
        end else if (RST) begin
            chk("mem_addr_rst", mem_addr, 0);
            chk("mem_wdata_rst", mem_wdata, 0);
        end
        chk("update", update, m_upd);
        chk("words", words, m_buf);
`ifdef CACHE_REFILL_PERF_EN
        chk("miss_cnt", miss_cnt, m_miss_cnt);
        chk("wb_cnt", wb_cnt, m_wb_cnt);
`endif
        obs_update = update;
        obs_stall  = stall;
        obs_req    = mem_req;
        obs_we     = mem_we;
        obs_addr   = mem_addr;
        obs_wdata  = mem_wdata;
        obs_words  = words;
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the model at the edge.
    task automatic cyc(input logic rst_v, input logic miss_v, input logic wb_v,
                       input logic [31:0] a_v, input logic [31:0] wa_v,
                       input logic [127:0] ww_v, input logic ack_v, input logic [127:0] rd_v);
        RST       = rst_v;
        miss      = miss_v;
        mem_wb    = wb_v;
        addr      = a_v;
        wb_addr   = wa_v;
        wb_words  = ww_v;
        mem_ack   = ack_v;
        mem_rdata = rd_v;
        if (rst_v) model_reset();
        #3;
        compare();
        @(posedge CLK);
        if (rst_v) model_reset();
        else model_step();
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] RD1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] RD2 = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
    localparam logic [127:0] WB1 = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;

    initial begin
        int upd_seen;
        model_reset();

        // Reset state, with miss held high: stall follows miss.
        cyc(1, 1, 0, 32'h0, 32'h0, '0, 0, '0);
        chk("rst_stall_eq_miss", obs_stall, 1'b1);
        chk("rst_mem_req", obs_req, 1'b0);
        chk("rst_words", obs_words, 128'h0);
        cyc(1, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        chk("rst_stall_idle", obs_stall, 1'b0);

        // Clean miss at 0x124 with zero-wait memory: update in cycle 3.
        cyc(0, 1, 0, 32'h124, 32'h0, '0, 0, '0);
        chk("clean_c1_stall", obs_stall, 1'b1);
        cyc(0, 1, 0, 32'h124, 32'h0, '0, 1, RD1);
        chk("clean_c2_addr", obs_addr, 32'h120);
        chk("clean_c2_we", obs_we, 1'b0);
        cyc(0, 0, 0, 32'h124, 32'h0, '0, 0, '0);
        chk("clean_c3_update", obs_update, 1'b1);
        chk("clean_c3_words", obs_words, RD1);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, '0);
        chk("clean_c4_stall", obs_stall, 1'b0);
        chk("clean_c4_words_held", obs_words, RD1);

        // Dirty miss, write-back acked after 5 wait cycles, inputs churn meanwhile.
        upd_seen = 0;
        cyc(0, 1, 1, 32'h3B8, 32'hA40, WB1, 0, '0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, $urandom, $urandom, rnd128(), 0, '0);
            chk("wb_wait_addr", obs_addr, 32'hA40);
            chk("wb_wait_data", obs_wdata, WB1);
            chk("wb_wait_we", obs_we, 1'b1);
        end
        cyc(0, 1, 1, $urandom, $urandom, rnd128(), 1, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, $urandom, $urandom, rnd128(), 0, '0);
            chk("fill_wait_addr", obs_addr, 32'h3B0);
            chk("fill_wait_wdata", obs_wdata, WB1);
        end
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, RD2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, '0);
            upd_seen += int'(obs_update);
        end
        chk("dirty_update_pulses", upd_seen, 1);
        chk("dirty_words", obs_words, RD2);

        // Reset during FILL: request drops at once, stale ack ignored, no install.
        cyc(0, 1, 0, 32'h500, 32'h0, '0, 0, '0);
        cyc(0, 1, 0, 32'h500, 32'h0, '0, 0, '0);
        chk("fill_before_rst", obs_req, 1'b1);
        cyc(1, 0, 0, 32'h500, 32'h0, '0, 0, '0);
        chk("rst_mid_req", obs_req, 1'b0);
        chk("rst_mid_words", obs_words, 128'h0);
        upd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, RD1);
            upd_seen += int'(obs_update);
            chk("post_rst_req", obs_req, 1'b0);
        end
        chk("post_rst_no_update", upd_seen, 0);

`ifdef CACHE_REFILL_PERF_EN
        // Three misses, one dirty.
        cyc(1, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        cyc(0, 1, 0, 32'h10, 32'h0, '0, 0, '0);
        cyc(0, 0, 0, 32'h10, 32'h0, '0, 1, RD1);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        cyc(0, 1, 1, 32'h20, 32'h80, WB1, 0, '0);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, '0);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, RD2);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        cyc(0, 1, 0, 32'h30, 32'h0, '0, 0, '0);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 1, RD1);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        cyc(0, 0, 0, 32'h0, 32'h0, '0, 0, '0);
        chk("perf_miss_cnt", miss_cnt, 32'd3);
        chk("perf_wb_cnt", wb_cnt, 32'd1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4), $urandom_range(0, 1),
                $urandom, {$urandom_range(0, 32'h0FFF_FFFF), 4'b0000}, rnd128(),
                $urandom_range(0, 1), rnd128());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
